// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT datapath: default modulus/width, butterfly mode
// encodings and modular add/sub helpers (operands zero-extended to MOD_FW bits).
package ntt_pkg;

    localparam int NTT_W  = 23;
    localparam int NTT_Q  = 8380417;
    localparam int MOD_FW = 32;

    localparam logic BU_MODE_CT = 1'b0;
    localparam logic BU_MODE_GS = 1'b1;

    function automatic logic [MOD_FW-1:0] mod_add(input logic [MOD_FW-1:0] u,
                                                  input logic [MOD_FW-1:0] v,
                                                  input logic [MOD_FW-1:0] q);
        logic [MOD_FW-1:0] s;
        s = u + v;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic logic [MOD_FW-1:0] mod_sub(input logic [MOD_FW-1:0] u,
                                                  input logic [MOD_FW-1:0] v,
                                                  input logic [MOD_FW-1:0] q);
        return (u < v) ? u + q - v : u - v;
    endfunction

endpackage

// File: rtl/mod_mul_pipe.sv
// Pipelined W x W modular multiplier: full product registered first, then exact
// reduction mod Q, with MUL_STAGES registers in total, all gated by en.
module mod_mul_pipe
    import ntt_pkg::*;
#(
    parameter int W          = NTT_W,
    parameter int Q          = NTT_Q,
    parameter int MUL_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    localparam logic [2*W-1:0] Q_WIDE = (2*W)'(Q);

    logic [2*W-1:0] prod_p1;
    logic [W-1:0]   red;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1 <= '0;
        end else if (en) begin
            prod_p1 <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
    end

    // Remainder is always < Q < 2^W, so the narrowing is lossless
    assign red = W'(prod_p1 % Q_WIDE);

    generate
        if (MUL_STAGES == 1) begin : g_one
            assign p = red;
        end else begin : g_many
            logic [W-1:0] red_q [MUL_STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MUL_STAGES-1; i++) red_q[i] <= '0;
                end else if (en) begin
                    red_q[0] <= red;
                    for (int i = 1; i < MUL_STAGES-1; i++) red_q[i] <= red_q[i-1];
                end
            end

            assign p = red_q[MUL_STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/ntt_bu_pipe.sv
// Dual-mode (CT/GS) pipelined NTT butterfly, latency MUL_STAGES+2, global stall.
// Define NTT_BU_HALVE_EN to scale GS outputs by 2^-1 mod Q in the post-stage.
module ntt_bu_pipe
    import ntt_pkg::*;
#(
    parameter int W          = NTT_W,
    parameter int Q          = NTT_Q,
    parameter int MUL_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] tf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a,
    output logic [W-1:0] b
);

    localparam logic [MOD_FW-1:0] QF = MOD_FW'(Q);

    logic                  adv;
    logic                  vld_p0, mode_p0;
    logic [W-1:0]          u_p0, v_p0, tf_p0;
    logic [MUL_STAGES-1:0] vld_p1, mode_p1;
    logic [W-1:0]          u_p1 [MUL_STAGES];
    logic [W-1:0]          m_p1;
    logic [W-1:0]          a_nxt, b_nxt;

`ifdef NTT_BU_HALVE_EN
    function automatic logic [W-1:0] halve(input logic [W-1:0] v);
        logic [W:0] t;
        t = v[0] ? ({1'b0, v} + (W+1)'(Q)) : {1'b0, v};
        return t[W:1];
    endfunction
`endif

    // The whole pipe freezes only when a finished beat is waiting on downstream
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Pre-stage: GS sum/difference, CT pass-through; v always feeds the multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            mode_p0 <= BU_MODE_CT;
            u_p0    <= '0;
            v_p0    <= '0;
            tf_p0   <= '0;
        end else if (adv) begin
            vld_p0  <= in_valid;
            mode_p0 <= mode;
            tf_p0   <= tf;
            if (mode == BU_MODE_CT) begin
                u_p0 <= x;
                v_p0 <= y;
            end else begin
                u_p0 <= W'(mod_add(MOD_FW'(x), MOD_FW'(y), QF));
                v_p0 <= W'(mod_sub(MOD_FW'(x), MOD_FW'(y), QF));
            end
        end
    end

    // Multiply stage: product of v and twiddle, with u/mode/valid delayed alongside
    mod_mul_pipe #(.W(W), .Q(Q), .MUL_STAGES(MUL_STAGES)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .a     (v_p0),
        .b     (tf_p0),
        .p     (m_p1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= '0;
            mode_p1 <= '0;
            for (int i = 0; i < MUL_STAGES; i++) u_p1[i] <= '0;
        end else if (adv) begin
            vld_p1[0]  <= vld_p0;
            mode_p1[0] <= mode_p0;
            u_p1[0]    <= u_p0;
            for (int i = 1; i < MUL_STAGES; i++) begin
                vld_p1[i]  <= vld_p1[i-1];
                mode_p1[i] <= mode_p1[i-1];
                u_p1[i]    <= u_p1[i-1];
            end
        end
    end

    // Post-stage: CT sum/difference, GS pass-through (optionally halved)
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        if (mode_p1[MUL_STAGES-1] == BU_MODE_GS) begin
            a_nxt = u_p1[MUL_STAGES-1];
            b_nxt = m_p1;
`ifdef NTT_BU_HALVE_EN
            a_nxt = halve(a_nxt);
            b_nxt = halve(b_nxt);
`endif
        end else begin
            a_nxt = W'(mod_add(MOD_FW'(u_p1[MUL_STAGES-1]), MOD_FW'(m_p1), QF));
            b_nxt = W'(mod_sub(MOD_FW'(u_p1[MUL_STAGES-1]), MOD_FW'(m_p1), QF));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
        end else if (adv) begin
            out_valid <= vld_p1[MUL_STAGES-1];
            a         <= a_nxt;
            b         <= b_nxt;
        end
    end

endmodule
